// File: rtl/cache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : cache_refill_ctrl_if
// Brief   : CPU / cache-array / memory signal bundle for cache_refill_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
interface cache_refill_ctrl_if #(
   parameter int ADDR_W = 15,
   parameter int WORD_W = 32,
   parameter int CNT_W  = 16
);
   logic                  cpu_req;
   logic [ADDR_W-1:0]     cpu_addr;
   logic                  cpu_ready;
   logic [WORD_W-1:0]     cpu_rdata;
   logic                  busy;
   logic                  cache_rd;
   logic [ADDR_W-1:0]     cache_addr;
   logic                  cache_hit;
   logic [WORD_W-1:0]     cache_rdata;
   logic                  cache_fill;
   logic [4*WORD_W-1:0]   cache_fill_data;
   logic                  mem_rd;
   logic [ADDR_W-1:0]     mem_addr;
   logic                  mem_ack;
   logic [WORD_W-1:0]     mem_rdata;
   logic [CNT_W-1:0]      hit_cnt;
   logic [CNT_W-1:0]      miss_cnt;

   modport master (
      input  cpu_req, cpu_addr, cache_hit, cache_rdata, mem_ack, mem_rdata,
      output cpu_ready, cpu_rdata, busy, cache_rd, cache_addr, cache_fill,
             cache_fill_data, mem_rd, mem_addr, hit_cnt, miss_cnt
   );

   modport slave (
      output cpu_req, cpu_addr, cache_hit, cache_rdata, mem_ack, mem_rdata,
      input  cpu_ready, cpu_rdata, busy, cache_rd, cache_addr, cache_fill,
             cache_fill_data, mem_rd, mem_addr, hit_cnt, miss_cnt
   );
endinterface
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cache_refill_ctrl
// Brief   : Single-outstanding read sequencer: cache lookup, 4-word refill.
// Revision: 1.0 - initial release
// ============================================================================
module cache_refill_ctrl #(
   parameter int ADDR_W = 15,
   parameter int WORD_W = 32,
   parameter int CNT_W  = 16
) (
   input wire                  clk,
   input wire                  rst,
   cache_refill_ctrl_if.master bus
);
   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_issue  = 3'd1;
   localparam logic [2:0] c_st_lookup = 3'd2;
   localparam logic [2:0] c_st_fetch  = 3'd3;
   localparam logic [2:0] c_st_gap    = 3'd4;
   localparam logic [2:0] c_st_fill   = 3'd5;
   localparam logic [2:0] c_st_resp   = 3'd6;

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_k;
   logic [WORD_W-1:0] r_buf [4];
   logic [WORD_W-1:0] r_rdata;
   logic [CNT_W-1:0]  r_hit_cnt;
   logic [CNT_W-1:0]  r_miss_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= c_st_idle;
         r_addr     <= '0;
         r_k        <= '0;
         r_rdata    <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         for (int i = 0; i < 4; i++) r_buf[i] <= '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (bus.cpu_req) begin
                  r_addr  <= bus.cpu_addr;
                  r_state <= c_st_issue;
               end
            end
            c_st_issue: r_state <= c_st_lookup;
            c_st_lookup: begin
               if (bus.cache_hit) begin
                  r_rdata <= bus.cache_rdata;
                  if (r_hit_cnt != c_cnt_max) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                  r_state <= c_st_resp;
               end else begin
                  if (r_miss_cnt != c_cnt_max) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                  r_k     <= 2'd0;
                  r_state <= c_st_fetch;
               end
            end
            c_st_fetch: begin
               if (bus.mem_ack) begin
                  r_buf[r_k] <= bus.mem_rdata;
                  if (r_k == 2'd3) begin
                     r_state <= c_st_fill;
                  end else begin
                     // Word index advances on leaving FETCH so mem_addr only moves during GAP
                     r_k     <= r_k + 2'd1;
                     r_state <= c_st_gap;
                  end
               end
            end
            c_st_gap: r_state <= c_st_fetch;
            c_st_fill: begin
               r_rdata <= r_buf[r_addr[1:0]];
               r_state <= c_st_resp;
            end
            c_st_resp: r_state <= c_st_idle;
            default:   r_state <= c_st_idle;
         endcase
      end
   end

   // Strobes are pure state decodes so an asynchronous reset drops them at once
   assign bus.busy            = (r_state != c_st_idle);
   assign bus.cache_rd        = (r_state == c_st_issue);
   assign bus.mem_rd          = (r_state == c_st_fetch);
   assign bus.cache_fill      = (r_state == c_st_fill);
   assign bus.cpu_ready       = (r_state == c_st_resp);
   assign bus.cpu_rdata       = r_rdata;
   assign bus.cache_addr      = r_addr;
   assign bus.mem_addr        = {r_addr[ADDR_W-1:2], r_k};
   assign bus.cache_fill_data = {r_buf[3], r_buf[2], r_buf[1], r_buf[0]};
   assign bus.hit_cnt         = r_hit_cnt;
   assign bus.miss_cnt        = r_miss_cnt;
endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_refill_ctrl
// Brief   : Scoreboard bench with cache-array and memory responder models.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cache_refill_ctrl;
   localparam int ADDR_W = 15;
   localparam int WORD_W = 32;
   localparam int CNT_W  = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   cache_refill_ctrl_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

   cache_refill_ctrl #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] data;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] cmodel [int];
   logic [15:0] exp_hit  = '0;
   logic [15:0] exp_miss = '0;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          last_ready_cyc = 0;

   function automatic logic [31:0] mem_word(input logic [14:0] a);
      if (a[14:2] == 13'h0011) return 32'hA0 + {30'd0, a[1:0]};
      return {12'hC00, 3'b000, a, 2'b00};
   endfunction

   // One CPU read: pushes the expectation, plays cache and memory, pops on cpu_ready
   task automatic do_request(input logic [14:0] addr, input int wait_cyc, input bit spur);
      exp_t         e;
      bit           hit;
      logic [127:0] exp_blk;
      int           k = 0, wcnt = 0, fills = 0, mem_cycles = 0;
      bit           prev_rd = 0, prev_ack = 0, ack_now, done = 0;
      @(negedge clk);
      hit    = cmodel.exists(int'(addr));
      e.data = hit ? cmodel[int'(addr)] : mem_word(addr);
      e.lat  = hit ? 3 : 11 + 4 * wait_cyc;
      for (int i = 0; i < 4; i++) exp_blk[32*i +: 32] = mem_word({addr[14:2], 2'(i)});
      sb.push_back(e);
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = addr;
      for (int c = 1; c <= 200 && !done; c++) begin
         @(negedge clk);
         ack_now = 0;
         if (spur) begin
            bus.cpu_req  = 1'($urandom);
            bus.cpu_addr = 15'($urandom);
         end else begin
            bus.cpu_req  = 1'b0;
         end
         if (prev_rd) begin
            bus.cache_hit   = hit;
            bus.cache_rdata = hit ? cmodel[int'(addr)] : 32'h0BAD0BAD;
         end else begin
            bus.cache_hit   = spur;
            bus.cache_rdata = spur ? $urandom : 32'h0;
         end
         n_checks++;
         if (bus.cache_rd !== (c == 1)) begin
            n_fail++;
            $display("FAIL cache_rd c=%0d: got %b expected %b", c, bus.cache_rd, (c == 1));
         end
         prev_rd = bus.cache_rd;
         if (bus.busy === 1'b1) begin
            n_checks++;
            if (bus.cache_addr !== addr) begin
               n_fail++;
               $display("FAIL cache_addr c=%0d: got %h expected %h", c, bus.cache_addr, addr);
            end
         end
         if (bus.mem_rd === 1'b1) begin
            mem_cycles++;
            n_checks++;
            if (bus.mem_addr !== {addr[14:2], 2'(k)}) begin
               n_fail++;
               $display("FAIL mem_addr c=%0d: got %h expected %h", c, bus.mem_addr, {addr[14:2], 2'(k)});
            end
            if (wcnt == wait_cyc) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = mem_word(bus.mem_addr);
               ack_now = 1;
               k++;
               wcnt = 0;
            end else begin
               bus.mem_ack   = 1'b0;
               bus.mem_rdata = $urandom;
               wcnt++;
            end
         end else begin
            bus.mem_ack   = spur;
            bus.mem_rdata = $urandom;
            wcnt = 0;
         end
         if (prev_ack) begin
            n_checks++;
            if (bus.mem_rd !== 1'b0) begin
               n_fail++;
               $display("FAIL mem_gap c=%0d: mem_rd got %b expected 0", c, bus.mem_rd);
            end
         end
         prev_ack = ack_now;
         if (bus.cache_fill === 1'b1) begin
            fills++;
            n_checks++;
            if (bus.cache_fill_data !== exp_blk) begin
               n_fail++;
               $display("FAIL fill_data: got %h expected %h", bus.cache_fill_data, exp_blk);
            end
            for (int i = 0; i < 4; i++)
               cmodel[int'({addr[14:2], 2'(i)})] = mem_word({addr[14:2], 2'(i)});
         end
         if (bus.cpu_ready === 1'b1) begin
            bus.cpu_req = 1'b0;
            done = 1;
            last_ready_cyc = cyc;
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL extra_ready: got cpu_ready with empty scoreboard, expected none");
            end else begin
               e = sb.pop_front();
               if (bus.cpu_rdata !== e.data) begin
                  n_fail++;
                  $display("FAIL cpu_rdata addr=%h: got %h expected %h", addr, bus.cpu_rdata, e.data);
               end
               n_checks++;
               if (c != e.lat) begin
                  n_fail++;
                  $display("FAIL latency addr=%h: got %0d expected %0d", addr, c, e.lat);
               end
            end
         end
      end
      bus.cpu_req = 1'b0; bus.mem_ack = 1'b0; bus.cache_hit = 1'b0;
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL timeout addr=%h: got no cpu_ready in 200 cycles, expected one", addr);
      end
      if (hit) begin if (exp_hit != 16'hFFFF) exp_hit++; end
      else begin if (exp_miss != 16'hFFFF) exp_miss++; end
      n_checks++;
      if (bus.hit_cnt !== exp_hit) begin
         n_fail++;
         $display("FAIL hit_cnt: got %h expected %h", bus.hit_cnt, exp_hit);
      end
      n_checks++;
      if (bus.miss_cnt !== exp_miss) begin
         n_fail++;
         $display("FAIL miss_cnt: got %h expected %h", bus.miss_cnt, exp_miss);
      end
      n_checks++;
      if (fills != (hit ? 0 : 1) || k != (hit ? 0 : 4) || (hit && mem_cycles != 0)) begin
         n_fail++;
         $display("FAIL refill_count addr=%h: got fills=%0d words=%0d mem_rd_cycles=%0d expected fills=%0d words=%0d",
                  addr, fills, k, mem_cycles, hit ? 0 : 1, hit ? 0 : 4);
      end
   endtask

   task automatic test_reset;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.cpu_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_cpu_ready: got %b expected 0", bus.cpu_ready); end
      n_checks++; if (bus.cpu_rdata !== '0)    begin n_fail++; $display("FAIL rst_cpu_rdata: got %h expected 0", bus.cpu_rdata); end
      n_checks++; if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.cache_rd !== 1'b0)   begin n_fail++; $display("FAIL rst_cache_rd: got %b expected 0", bus.cache_rd); end
      n_checks++; if (bus.cache_fill !== 1'b0) begin n_fail++; $display("FAIL rst_cache_fill: got %b expected 0", bus.cache_fill); end
      n_checks++; if (bus.cache_fill_data !== '0) begin n_fail++; $display("FAIL rst_fill_data: got %h expected 0", bus.cache_fill_data); end
      n_checks++; if (bus.cache_addr !== '0)   begin n_fail++; $display("FAIL rst_cache_addr: got %h expected 0", bus.cache_addr); end
      n_checks++; if (bus.mem_rd !== 1'b0)     begin n_fail++; $display("FAIL rst_mem_rd: got %b expected 0", bus.mem_rd); end
      n_checks++; if (bus.mem_addr !== '0)     begin n_fail++; $display("FAIL rst_mem_addr: got %h expected 0", bus.mem_addr); end
      n_checks++; if (bus.hit_cnt !== '0)      begin n_fail++; $display("FAIL rst_hit_cnt: got %h expected 0", bus.hit_cnt); end
      n_checks++; if (bus.miss_cnt !== '0)     begin n_fail++; $display("FAIL rst_miss_cnt: got %h expected 0", bus.miss_cnt); end
      rst = 1'b0;
   endtask

   task automatic test_hit;
      cmodel[int'(15'h0012)] = 32'hDEADBEEF;
      do_request(15'h0012, 0, 0);
   endtask

   task automatic test_miss_zero_wait;
      do_request(15'h0046, 0, 0);
   endtask

   task automatic test_miss_wait3;
      do_request(15'h0123, 3, 0);
   endtask

   task automatic test_back_to_back;
      int t0;
      do_request(15'h0012, 0, 0);
      t0 = last_ready_cyc;
      do_request(15'h0047, 0, 0);
      n_checks++;
      if (last_ready_cyc - t0 != 4) begin
         n_fail++;
         $display("FAIL b2b_spacing: got %0d expected 4", last_ready_cyc - t0);
      end
   endtask

   task automatic test_reset_mid_fetch;
      int acks = 0;
      bit fired = 0;
      @(negedge clk);
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 15'h0200;
      for (int c = 1; c <= 100 && !fired; c++) begin
         @(negedge clk);
         bus.cpu_req   = 1'b0;
         bus.cache_hit = 1'b0;
         bus.mem_ack   = 1'b0;
         if (bus.mem_rd === 1'b1) begin
            if (acks == 2) begin
               #2 rst = 1'b1;
               #1;
               fired = 1;
               n_checks++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_rd: got %b expected 0", bus.mem_rd); end
               n_checks++; if (bus.busy !== 1'b0)   begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
               n_checks++; if (bus.hit_cnt !== '0)  begin n_fail++; $display("FAIL rstmid_hit_cnt: got %h expected 0", bus.hit_cnt); end
               n_checks++; if (bus.miss_cnt !== '0) begin n_fail++; $display("FAIL rstmid_miss_cnt: got %h expected 0", bus.miss_cnt); end
               n_checks++; if (bus.cache_fill_data !== '0) begin n_fail++; $display("FAIL rstmid_buf: got %h expected 0", bus.cache_fill_data); end
            end else begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = mem_word(bus.mem_addr);
               acks++;
            end
         end
      end
      n_checks++;
      if (!fired) begin
         n_fail++;
         $display("FAIL rstmid_reach: got %0d words acked, expected third FETCH within 100 cycles", acks);
         rst = 1'b1;
      end
      bus.mem_ack = 1'b0;
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (bus.cache_fill !== 1'b0 || bus.mem_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: got fill=%b mem_rd=%b expected 0 0", bus.cache_fill, bus.mem_rd);
         end
      end
      rst = 1'b0;
      exp_hit  = '0;
      exp_miss = '0;
      do_request(15'h0201, 1, 0);
   endtask

   task automatic test_saturation;
      @(negedge clk);
      force dut.r_hit_cnt = 16'hFFFE;
      #1 release dut.r_hit_cnt;
      exp_hit = 16'hFFFE;
      n_checks++;
      if (bus.hit_cnt !== 16'hFFFE) begin
         n_fail++;
         $display("FAIL sat_preload: got %h expected fffe", bus.hit_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         do_request(15'h0012, 0, 0);
         n_checks++;
         if (bus.hit_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hit_%0d: got %h expected ffff", i, bus.hit_cnt);
         end
      end
   endtask

   task automatic test_spurious;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.mem_ack     = 1'b1;
         bus.cache_hit   = 1'b1;
         bus.cache_rdata = $urandom;
         n_checks++;
         if (bus.busy !== 1'b0 || bus.cpu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_idle: got busy=%b ready=%b expected 0 0", bus.busy, bus.cpu_ready);
         end
      end
      bus.mem_ack   = 1'b0;
      bus.cache_hit = 1'b0;
      do_request(15'h0012, 0, 1);
      do_request(15'h0333, 1, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.cpu_ready !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_after: got ready=%b busy=%b expected 0 0", bus.cpu_ready, bus.busy);
         end
      end
   endtask

   initial begin
      bus.cpu_req = 1'b0; bus.cpu_addr = '0;
      bus.cache_hit = 1'b0; bus.cache_rdata = '0;
      bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      test_reset();
      test_hit();
      test_miss_zero_wait();
      test_miss_wait3();
      test_back_to_back();
      test_reset_mid_fetch();
      test_saturation();
      test_spurious();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got simulation still running at 1ms, expected completion");
      $fatal(1);
   end
endmodule
`default_nettype wire
